// File: rtl/frenzy_mem_pkg.sv
// Shared types for the Frenzy memory arbiter slice.
//   state_t     boot/load/drain/hold/run sequencing of the core
//   rd_state_t  progress of the single outstanding CPU read
//   wr_entry_t  one buffered download write (address + byte)
package frenzy_mem_pkg;

  // Width of every address in the slice.
  // wr_entry_t is sized from this value.
  localparam int ADDR_W_DEFAULT = 16;

  typedef enum logic [2:0] {
    BOOT,
    LOAD,
    DRAIN,
    HOLD,
    RUN
  } state_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_REQ,
    RD_CAP
  } rd_state_t;

  typedef struct packed {
    logic [ADDR_W_DEFAULT-1:0] addr;
    logic [7:0]                data;
  } wr_entry_t;

endpackage

// File: rtl/frenzy_dl_fifo.sv
// Download write buffer: a small synchronous FIFO of wr_entry_t.
// Ports:
//   clk_sys     system clock
//   reset       asynchronous, active-high; empties the FIFO
//   push        write push_entry (ignored when full unless popping the same edge)
//   push_entry  entry to store
//   pop         discard head (ignored when empty)
//   head        oldest entry, valid while !empty
//   full/empty  occupancy flags
//   count       number of stored entries
module frenzy_dl_fifo
  import frenzy_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     push,
  input  wr_entry_t                push_entry,
  input  logic                     pop,
  output wr_entry_t                head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wr_entry_t         storage [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign head    = storage[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The storage array needs no reset.
  // Emptying the pointers and count discards its contents.
  always_ff @(posedge clk_sys) begin
    if (do_push) storage[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/frenzy_mem_arbiter.sv
// Shares one 8-bit memory port between the HPS ROM download stream and
// CPU reads, and sequences core reset through BOOT/LOAD/DRAIN/HOLD/RUN.
// Ports:
//   clk_sys, reset                      clock, async active-high reset
//   dl_active/dl_wr/dl_addr/dl_data     hps_io download stream
//   cpu_rd_req/cpu_addr                 read request, taken while cpu_rd_ready
//   cpu_rd_ready/cpu_rd_valid/cpu_rd_data  read handshake and result
//   mem_addr/mem_wdata/mem_we/mem_re    shared port request (held until mem_ready)
//   mem_ready/mem_rdata                 port completion and read data (cycle after)
//   core_reset/dl_done                  core reset, high except in RUN / high in RUN
//   dl_checksum/dl_overflow             mod-256 sum of accepted bytes, sticky drop flag
module frenzy_mem_arbiter
  import frenzy_mem_pkg::*;
#(
  parameter int          ADDR_W      = ADDR_W_DEFAULT,
  parameter int unsigned MEM_SIZE    = 32'hC000,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          HOLD_CYCLES = 64
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              dl_active,
  input  logic              dl_wr,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [7:0]        dl_data,
  input  logic              cpu_rd_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_rd_ready,
  output logic              cpu_rd_valid,
  output logic [7:0]        cpu_rd_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic              mem_ready,
  input  logic [7:0]        mem_rdata,
  output logic              core_reset,
  output logic              dl_done,
  output logic [7:0]        dl_checksum,
  output logic              dl_overflow
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;

  state_t             state;
  state_t             next_state;
  rd_state_t          rd_state;
  rd_state_t          rd_next;
  logic               rd_issued;
  logic [ADDR_W-1:0]  rd_addr;
  logic [HOLD_W-1:0]  hold_cnt;

  logic               entering_load;
  logic               entering_hold;
  logic               in_range;
  logic               push_want;
  logic               push_ok;
  logic               push_drop;

  wr_entry_t          push_entry;
  wr_entry_t          fifo_head;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;

  // ---------------------------------------------------------------
  // Download write buffer
  // ---------------------------------------------------------------
  assign push_entry.addr = dl_addr;
  assign push_entry.data = dl_data;

  frenzy_dl_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .push       (push_ok),
    .push_entry (push_entry),
    .pop        (fifo_pop),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  // Out-of-range writes vanish entirely.
  // They neither buffer, sum, nor count as overflow.
  assign in_range  = (32'(dl_addr) < MEM_SIZE);
  assign push_want = (state == LOAD) && dl_wr && in_range;
  assign push_ok   = push_want && (!fifo_full || fifo_pop);
  assign push_drop = push_want && !push_ok;

  // ---------------------------------------------------------------
  // Port arbitration
  // ---------------------------------------------------------------
  // Buffered writes win over a waiting read.
  // Once mem_re has been presented without completing (rd_issued), the read keeps the port.
  // That holds even if new writes arrive, since requests are never preempted.
  assign mem_re   = (rd_state == RD_REQ) && (rd_issued || fifo_empty);
  assign mem_we   = !fifo_empty && !rd_issued;
  assign fifo_pop = mem_we && mem_ready;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (mem_we) begin
      mem_addr  = fifo_head.addr;
      mem_wdata = fifo_head.data;
    end else if (mem_re) begin
      mem_addr  = rd_addr;
    end
  end

  // ---------------------------------------------------------------
  // Core sequencing FSM
  // ---------------------------------------------------------------
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= BOOT;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      BOOT:    if (dl_active) next_state = LOAD;
      LOAD:    if (!dl_active) next_state = DRAIN;
      // The FIFO only holds entries while a write is still owed to memory.
      // So an empty FIFO also means no write is in flight.
      DRAIN:   if (fifo_count == '0) next_state = HOLD;
      HOLD:    if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) next_state = RUN;
      RUN:     if (dl_active) next_state = LOAD;
      default: next_state = BOOT;
    endcase
  end

  assign entering_load = (state != LOAD) && (next_state == LOAD);
  assign entering_hold = (state != HOLD) && (next_state == HOLD);
  assign core_reset    = (state != RUN);
  assign dl_done       = (state == RUN);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)              hold_cnt <= '0;
    else if (entering_hold) hold_cnt <= '0;
    else if (state == HOLD) hold_cnt <= hold_cnt + 1'b1;
  end

  // Checksum and overflow describe one download.
  // They restart whenever a new LOAD begins.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dl_checksum <= '0;
      dl_overflow <= 1'b0;
    end else if (entering_load) begin
      dl_checksum <= '0;
      dl_overflow <= 1'b0;
    end else begin
      if (push_ok)   dl_checksum <= dl_checksum + dl_data;
      if (push_drop) dl_overflow <= 1'b1;
    end
  end

  // ---------------------------------------------------------------
  // CPU read holding register
  // ---------------------------------------------------------------
  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE: if (cpu_rd_req) rd_next = RD_REQ;
      RD_REQ:  if (mem_re && mem_ready) rd_next = RD_CAP;
      RD_CAP:  rd_next = RD_IDLE;
      default: rd_next = RD_IDLE;
    endcase
  end

  assign cpu_rd_ready = (rd_state == RD_IDLE);

  // RD_CAP is the cycle in which memory returns the byte.
  // The byte is captured on the following edge, together with the valid pulse.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      rd_state     <= RD_IDLE;
      rd_issued    <= 1'b0;
      rd_addr      <= '0;
      cpu_rd_valid <= 1'b0;
      cpu_rd_data  <= '0;
    end else begin
      rd_state     <= rd_next;
      rd_issued    <= mem_re && !mem_ready;
      cpu_rd_valid <= (rd_state == RD_CAP);
      if ((rd_state == RD_IDLE) && cpu_rd_req) rd_addr <= cpu_addr;
      if (rd_state == RD_CAP) cpu_rd_data <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_frenzy_mem_arbiter.sv
// Directed self-checking bench for frenzy_mem_arbiter.
// Drives the download stream and CPU reads against a byte-array memory model.
// Every write reaching the shared port is logged and compared in order.
module tb_frenzy_mem_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        dl_active;
  logic        dl_wr;
  logic [15:0] dl_addr;
  logic [7:0]  dl_data;
  logic        cpu_rd_req;
  logic [15:0] cpu_addr;
  logic        cpu_rd_ready;
  logic        cpu_rd_valid;
  logic [7:0]  cpu_rd_data;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic        mem_ready;
  logic [7:0]  mem_rdata;
  logic        core_reset;
  logic        dl_done;
  logic [7:0]  dl_checksum;
  logic        dl_overflow;

  int checks;
  int errors;

  logic [7:0]  mem_model [0:65535];
  logic [23:0] wr_log [$];

  frenzy_mem_arbiter dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .dl_active    (dl_active),
    .dl_wr        (dl_wr),
    .dl_addr      (dl_addr),
    .dl_data      (dl_data),
    .cpu_rd_req   (cpu_rd_req),
    .cpu_addr     (cpu_addr),
    .cpu_rd_ready (cpu_rd_ready),
    .cpu_rd_valid (cpu_rd_valid),
    .cpu_rd_data  (cpu_rd_data),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_re       (mem_re),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .core_reset   (core_reset),
    .dl_done      (dl_done),
    .dl_checksum  (dl_checksum),
    .dl_overflow  (dl_overflow)
  );

  always #5 clk_sys = ~clk_sys;

  // Memory model: a request completes on an edge where it is presented with mem_ready.
  // Read data appears in the following cycle.
  always @(posedge clk_sys) begin
    if (mem_we && mem_ready) begin
      mem_model[mem_addr] <= mem_wdata;
      wr_log.push_back({mem_addr, mem_wdata});
    end
    if (mem_re && mem_ready) mem_rdata <= mem_model[mem_addr];
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic applyStimulus(input logic act, input logic wr,
                               input logic [15:0] addr, input logic [7:0] data);
    dl_active = act;
    dl_wr     = wr;
    dl_addr   = addr;
    dl_data   = data;
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    dl_active  = 1'b0;
    dl_wr      = 1'b0;
    dl_addr    = '0;
    dl_data    = '0;
    cpu_rd_req = 1'b0;
    cpu_addr   = '0;
    mem_ready  = 1'b1;
    #2;

    $display("[TB] reset values");
    checkOutput("rst_core_reset", core_reset, 1);
    checkOutput("rst_dl_done", dl_done, 0);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_mem_re", mem_re, 0);
    checkOutput("rst_rd_ready", cpu_rd_ready, 1);
    checkOutput("rst_rd_valid", cpu_rd_valid, 0);
    checkOutput("rst_rd_data", cpu_rd_data, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_wdata", mem_wdata, 0);
    checkOutput("rst_checksum", dl_checksum, 0);
    checkOutput("rst_overflow", dl_overflow, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    checkOutput("boot_core_reset", core_reset, 1);
    checkOutput("boot_dl_done", dl_done, 0);

    $display("[TB] download 10,20,30");
    applyStimulus(1, 0, 16'h0000, 8'h00);
    applyStimulus(1, 1, 16'h0000, 8'd10);
    checkOutput("dl0_we", mem_we, 1);
    checkOutput("dl0_addr", mem_addr, 16'h0000);
    checkOutput("dl0_data", mem_wdata, 8'd10);
    applyStimulus(1, 1, 16'h0001, 8'd20);
    checkOutput("dl1_we", mem_we, 1);
    checkOutput("dl1_addr", mem_addr, 16'h0001);
    checkOutput("dl1_data", mem_wdata, 8'd20);
    applyStimulus(1, 1, 16'h0002, 8'd30);
    checkOutput("dl2_we", mem_we, 1);
    checkOutput("dl2_addr", mem_addr, 16'h0002);
    checkOutput("dl2_data", mem_wdata, 8'd30);
    checkOutput("dl_checksum60", dl_checksum, 8'd60);
    applyStimulus(0, 0, 16'h0000, 8'h00);
    checkOutput("drain_we_idle", mem_we, 0);
    checkOutput("drain_core_reset", core_reset, 1);
    tick();
    repeat (63) tick();
    checkOutput("hold63_core_reset", core_reset, 1);
    checkOutput("hold63_dl_done", dl_done, 0);
    tick();
    checkOutput("hold64_core_reset", core_reset, 0);
    checkOutput("hold64_dl_done", dl_done, 1);
    checkOutput("dl_log_size", wr_log.size(), 3);
    checkOutput("dl_log0", wr_log[0], {16'h0000, 8'd10});
    checkOutput("dl_log1", wr_log[1], {16'h0001, 8'd20});
    checkOutput("dl_log2", wr_log[2], {16'h0002, 8'd30});

    $display("[TB] range and overflow");
    mem_ready = 1'b0;
    applyStimulus(1, 0, 16'h0000, 8'h00);
    checkOutput("load_cksum_clear", dl_checksum, 0);
    checkOutput("load_core_reset", core_reset, 1);
    applyStimulus(1, 1, 16'hC000, 8'hFF);
    checkOutput("range_we", mem_we, 0);
    checkOutput("range_checksum", dl_checksum, 0);
    checkOutput("range_overflow", dl_overflow, 0);
    applyStimulus(1, 1, 16'h0001, 8'h5A);
    applyStimulus(1, 1, 16'h0002, 8'h5B);
    applyStimulus(1, 1, 16'h0003, 8'h5C);
    applyStimulus(1, 1, 16'h0004, 8'h5D);
    checkOutput("ovf_full_no_flag", dl_overflow, 0);
    applyStimulus(1, 1, 16'h0005, 8'h5E);
    checkOutput("ovf_flag", dl_overflow, 1);
    checkOutput("ovf_checksum", dl_checksum, 8'h6E);
    checkOutput("ovf_we_held", mem_we, 1);
    checkOutput("ovf_head_addr", mem_addr, 16'h0001);
    checkOutput("ovf_head_data", mem_wdata, 8'h5A);
    mem_ready = 1'b1;
    applyStimulus(1, 0, 16'h0000, 8'h00);
    repeat (3) tick();
    checkOutput("ovf_drained_we", mem_we, 0);
    checkOutput("ovf_log_size", wr_log.size(), 7);
    checkOutput("ovf_log3", wr_log[3], {16'h0001, 8'h5A});
    checkOutput("ovf_log4", wr_log[4], {16'h0002, 8'h5B});
    checkOutput("ovf_log5", wr_log[5], {16'h0003, 8'h5C});
    checkOutput("ovf_log6", wr_log[6], {16'h0004, 8'h5D});
    applyStimulus(0, 0, 16'h0000, 8'h00);
    for (int i = 0; i < 200 && !dl_done; i++) tick();
    checkOutput("run_reached", dl_done, 1);

    $display("[TB] read in RUN");
    cpu_rd_req = 1'b1;
    cpu_addr   = 16'h0001;
    tick();
    cpu_rd_req = 1'b0;
    cpu_addr   = 16'h0000;
    checkOutput("rd_ready_low", cpu_rd_ready, 0);
    checkOutput("rd_mem_re", mem_re, 1);
    checkOutput("rd_mem_we", mem_we, 0);
    checkOutput("rd_mem_addr", mem_addr, 16'h0001);
    tick();
    checkOutput("rd_re_dropped", mem_re, 0);
    checkOutput("rd_valid_early", cpu_rd_valid, 0);
    checkOutput("rd_ready_wait", cpu_rd_ready, 0);
    tick();
    checkOutput("rd_valid", cpu_rd_valid, 1);
    checkOutput("rd_data", cpu_rd_data, 8'h5A);
    checkOutput("rd_ready_back", cpu_rd_ready, 1);
    tick();
    checkOutput("rd_valid_pulse", cpu_rd_valid, 0);
    checkOutput("rd_data_held", cpu_rd_data, 8'h5A);

    $display("[TB] contention");
    mem_ready = 1'b0;
    applyStimulus(1, 0, 16'h0000, 8'h00);
    applyStimulus(1, 1, 16'h0020, 8'h11);
    applyStimulus(1, 1, 16'h0021, 8'h22);
    dl_wr      = 1'b0;
    cpu_rd_req = 1'b1;
    cpu_addr   = 16'h0002;
    tick();
    cpu_rd_req = 1'b0;
    checkOutput("ct_ready_low", cpu_rd_ready, 0);
    checkOutput("ct_re_blocked", mem_re, 0);
    checkOutput("ct_we0", mem_we, 1);
    checkOutput("ct_addr0", mem_addr, 16'h0020);
    checkOutput("ct_checksum", dl_checksum, 8'h33);
    mem_ready = 1'b1;
    tick();
    checkOutput("ct_re_blocked1", mem_re, 0);
    checkOutput("ct_we1", mem_we, 1);
    checkOutput("ct_addr1", mem_addr, 16'h0021);
    tick();
    checkOutput("ct_we_done", mem_we, 0);
    checkOutput("ct_re_issued", mem_re, 1);
    checkOutput("ct_re_addr", mem_addr, 16'h0002);
    tick();
    tick();
    checkOutput("ct_valid", cpu_rd_valid, 1);
    checkOutput("ct_data", cpu_rd_data, 8'h5B);
    checkOutput("ct_log_size", wr_log.size(), 9);

    $display("[TB] abort during LOAD");
    mem_ready = 1'b0;
    applyStimulus(1, 1, 16'h0030, 8'h40);
    applyStimulus(1, 1, 16'h0031, 8'h41);
    applyStimulus(1, 1, 16'h0032, 8'h42);
    dl_wr = 1'b0;
    checkOutput("ab_we", mem_we, 1);
    checkOutput("ab_addr", mem_addr, 16'h0030);
    checkOutput("ab_checksum", dl_checksum, 8'hF6);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("ab_rst_we", mem_we, 0);
    checkOutput("ab_rst_core_reset", core_reset, 1);
    checkOutput("ab_rst_ready", cpu_rd_ready, 1);
    checkOutput("ab_rst_checksum", dl_checksum, 0);
    checkOutput("ab_rst_mem_addr", mem_addr, 0);
    mem_ready = 1'b1;
    dl_active = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("ab_no_we", mem_we, 0);
    end
    checkOutput("ab_log_size", wr_log.size(), 9);
    checkOutput("ab_dl_done", dl_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
